// File: rtl/aes_round_ctrl_pkg.sv
// aes_round_ctrl_pkg: shared widths, round count and FSM encoding for the AES round sequencer
package aes_round_ctrl_pkg;
  localparam int AES_BLK_W = 128;
  localparam int AES_NR = 10;
  localparam int KEY_IDX_W = 4;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;
endpackage

// File: rtl/aes_round_ctrl_if.sv
// aes_round_ctrl_if: host-facing plaintext-in / ciphertext-out valid/ready block bus
// master = host side (offers plaintext, takes ciphertext); slave = sequencer side
interface aes_round_ctrl_if;
  import aes_round_ctrl_pkg::*;
  logic in_valid;
  logic in_ready;
  logic [AES_BLK_W-1:0] in_data;
  logic out_valid;
  logic out_ready;
  logic [AES_BLK_W-1:0] out_data;
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
  modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative AES-128 sequencer driving one external round datapath
// ports: clk/rst (sync, active-high); blk = host block bus (slave);
//   key_idx_o/key_i = round-key store lookup; rnd_* = round datapath; busy = not IDLE
module aes_round_ctrl
  import aes_round_ctrl_pkg::*;
#(
  parameter int NR = AES_NR,
  parameter int ROUND_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  aes_round_ctrl_if.slave      blk,
  output logic [KEY_IDX_W-1:0] key_idx_o,
  input  logic [AES_BLK_W-1:0] key_i,
  output logic                 rnd_start,
  output logic                 rnd_last,
  output logic [AES_BLK_W-1:0] rnd_state_o,
  output logic [AES_BLK_W-1:0] rnd_key_o,
  input  logic [AES_BLK_W-1:0] rnd_state_i,
  output logic                 busy
);
  localparam int WW = ROUND_LATENCY > 1 ? $clog2(ROUND_LATENCY) : 1;
  state_e r_state, w_next;
  logic [KEY_IDX_W-1:0] r_rnd;
  logic [WW-1:0] r_wcnt;
  logic [AES_BLK_W-1:0] r_blk;
  logic w_acc, w_cap, w_take, w_last, w_run;
  assign w_take = r_state == S_DONE && blk.out_ready;
  assign w_acc = blk.in_valid && blk.in_ready;
  assign w_cap = r_state == S_WAIT && r_wcnt == '0;
  assign w_last = r_rnd == KEY_IDX_W'(NR);
  assign w_run = r_state == S_ISSUE || r_state == S_WAIT;
  always_ff @(posedge clk)
    if (rst) r_state <= S_IDLE;
    else r_state <= w_next;
  // accept wins in DONE so a retiring block and a new one share an edge
  always_comb
    w_next = w_acc ? S_ISSUE :
             r_state == S_ISSUE ? S_WAIT :
             w_cap ? (w_last ? S_DONE : S_ISSUE) :
             w_take ? S_IDLE : r_state;
  always_comb begin
    blk.in_ready = r_state == S_IDLE || w_take;
    blk.out_valid = r_state == S_DONE;
    blk.out_data = r_blk;
    rnd_start = r_state == S_ISSUE;
    rnd_last = w_run && w_last;
    key_idx_o = w_run ? r_rnd : '0;
    rnd_state_o = r_blk;
    rnd_key_o = key_i;
    busy = r_state != S_IDLE;
  end
  // key_i tracks key_idx_o, which is round 0 whenever a block can be accepted
  always_ff @(posedge clk)
    if (rst) begin
      r_rnd <= '0;
      r_wcnt <= '0;
      r_blk <= '0;
    end else begin
      if (w_acc) begin
        r_blk <= blk.in_data ^ key_i;
        r_rnd <= KEY_IDX_W'(1);
      end else if (w_cap) begin
        r_blk <= rnd_state_i;
        if (!w_last) r_rnd <= r_rnd + 1'b1;
      end
      if (r_state == S_ISSUE) r_wcnt <= WW'(ROUND_LATENCY - 1);
      else if (r_state == S_WAIT && r_wcnt != '0) r_wcnt <= r_wcnt - 1'b1;
    end
endmodule
